// File: rtl/despertador_pkg.sv
// Shared types and constants for the despertador alarm clock.
// The ADIADO state exists only when SONECA_EN is defined.
package despertador_pkg;

  localparam int HORAS_DIA   = 24;
  localparam int MIN_HORA    = 60;
  localparam int DIAS_SEMANA = 7;

  localparam int W_HORA = 5;
  localparam int W_MIN  = 6;
  localparam int W_DIA  = 3;

`ifdef SONECA_EN
  typedef enum logic [1:0] {INATIVO, ARMADO, TOCANDO, ADIADO} estado_t;
`else
  typedef enum logic [1:0] {INATIVO, ARMADO, TOCANDO} estado_t;
`endif

  // Monday (1) through Friday (5) are working days; 0 is Sunday.
  function automatic logic eh_dia_util(input logic [W_DIA-1:0] dia);
    return (dia >= W_DIA'(1)) && (dia <= W_DIA'(5));
  endfunction

endpackage

// File: rtl/relogio_hms.sv
// Time-of-day and day-of-week counters driven by a 1 Hz strobe.
// Exposes the next hour/minute so the alarm can compare in the same cycle.
module relogio_hms
  import despertador_pkg::*;
#(
  parameter int SEG_POR_MIN = 60
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pulso_seg,
  input  logic              carregar,
  input  logic [W_HORA-1:0] hora_in,
  input  logic [W_MIN-1:0]  min_in,
  input  logic [W_DIA-1:0]  dia_in,
  output logic              evento_min,
  output logic [W_HORA-1:0] hora_prox,
  output logic [W_MIN-1:0]  minuto_prox,
  output logic [W_HORA-1:0] hora,
  output logic [W_MIN-1:0]  minuto,
  output logic [W_DIA-1:0]  dia_semana,
  output logic              dia_util
);

  localparam int SEG_W = (SEG_POR_MIN > 1) ? $clog2(SEG_POR_MIN) : 1;
  localparam logic [SEG_W-1:0] SEG_MAX = SEG_W'(SEG_POR_MIN - 1);

  logic [SEG_W-1:0]  seg_reg, seg_next;
  logic [W_MIN-1:0]  min_reg, min_next;
  logic [W_HORA-1:0] hora_reg, hora_next;
  logic [W_DIA-1:0]  dia_reg, dia_next;
  logic              util_reg;
  logic              fim_min, fim_hora, fim_dia;

  assign fim_min  = (min_reg == W_MIN'(MIN_HORA - 1));
  assign fim_hora = (hora_reg == W_HORA'(HORAS_DIA - 1));
  assign fim_dia  = (dia_reg == W_DIA'(DIAS_SEMANA - 1));

  // A load suppresses the second tick, so no minute event can come from it.
  always_comb begin
    seg_next   = seg_reg;
    min_next   = min_reg;
    hora_next  = hora_reg;
    dia_next   = dia_reg;
    evento_min = 1'b0;
    if (carregar) begin
      seg_next  = '0;
      min_next  = min_in;
      hora_next = hora_in;
      dia_next  = dia_in;
    end else if (pulso_seg) begin
      if (seg_reg == SEG_MAX) begin
        seg_next   = '0;
        evento_min = 1'b1;
        min_next   = fim_min ? '0 : min_reg + W_MIN'(1);
        if (fim_min) begin
          hora_next = fim_hora ? '0 : hora_reg + W_HORA'(1);
          if (fim_hora) begin
            dia_next = fim_dia ? '0 : dia_reg + W_DIA'(1);
          end
        end
      end else begin
        seg_next = seg_reg + SEG_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_reg  <= '0;
      min_reg  <= '0;
      hora_reg <= '0;
      dia_reg  <= '0;
      util_reg <= 1'b0;
    end else begin
      seg_reg  <= seg_next;
      min_reg  <= min_next;
      hora_reg <= hora_next;
      dia_reg  <= dia_next;
      util_reg <= eh_dia_util(dia_next);
    end
  end

  assign hora_prox   = hora_next;
  assign minuto_prox = min_next;
  assign hora        = hora_reg;
  assign minuto      = min_reg;
  assign dia_semana  = dia_reg;
  assign dia_util    = util_reg;

endmodule

// File: rtl/despertador.sv
// Alarm-clock top: time keeping, alarm register, ring FSM and timeout.
// Define SONECA_EN to enable the snooze (adiar) path and the ADIADO state.
module despertador
  import despertador_pkg::*;
#(
  parameter int SEG_POR_MIN = 60,
  parameter int TIMEOUT_MIN = 10,
  parameter int SONECA_MIN  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pulso_seg,
  input  logic              carregar_hora,
  input  logic [W_HORA-1:0] hora_in,
  input  logic [W_MIN-1:0]  min_in,
  input  logic [W_DIA-1:0]  dia_in,
  input  logic              carregar_alarme,
  input  logic [W_HORA-1:0] alarme_hora,
  input  logic [W_MIN-1:0]  alarme_min,
  input  logic              armar,
  input  logic              desligar,
  input  logic              adiar,
  output logic              alarme,
  output logic              dia_util,
  output logic [W_HORA-1:0] hora,
  output logic [W_MIN-1:0]  minuto,
  output logic [W_DIA-1:0]  dia_semana
);

  localparam int TO_W = $clog2(TIMEOUT_MIN + 1);

  logic              evento_min;
  logic [W_HORA-1:0] hora_prox;
  logic [W_MIN-1:0]  minuto_prox;
  logic              bate_hora;

  estado_t           estado_reg, estado_next;
  logic [W_HORA-1:0] al_hora_reg, al_hora_next;
  logic [W_MIN-1:0]  al_min_reg, al_min_next;
  logic [TO_W-1:0]   to_reg, to_next;
  logic              alarme_reg;

`ifdef SONECA_EN
  localparam int SN_W = $clog2(SONECA_MIN + 1);
  logic [SN_W-1:0] sn_reg, sn_next;
`else
  logic [1:0] unused_cfg;
  assign unused_cfg = {adiar, SONECA_MIN[0]};
`endif

  relogio_hms #(
    .SEG_POR_MIN(SEG_POR_MIN)
  ) u_relogio (
    .clock      (clock),
    .reset      (reset),
    .pulso_seg  (pulso_seg),
    .carregar   (carregar_hora),
    .hora_in    (hora_in),
    .min_in     (min_in),
    .dia_in     (dia_in),
    .evento_min (evento_min),
    .hora_prox  (hora_prox),
    .minuto_prox(minuto_prox),
    .hora       (hora),
    .minuto     (minuto),
    .dia_semana (dia_semana),
    .dia_util   (dia_util)
  );

  // Only a minute advance can match; a time load never raises evento_min.
  assign bate_hora = evento_min && (hora_prox == al_hora_reg) && (minuto_prox == al_min_reg);

  always_comb begin
    estado_next  = estado_reg;
    to_next      = to_reg;
    al_hora_next = al_hora_reg;
    al_min_next  = al_min_reg;
`ifdef SONECA_EN
    sn_next      = sn_reg;
`endif
    if (carregar_alarme) begin
      al_hora_next = alarme_hora;
      al_min_next  = alarme_min;
    end
    if (!armar) begin
      estado_next = INATIVO;
      to_next     = '0;
`ifdef SONECA_EN
      sn_next     = '0;
`endif
    end else begin
      case (estado_reg)
        INATIVO: estado_next = ARMADO;
        ARMADO: begin
          if (!carregar_alarme && bate_hora) begin
            estado_next = TOCANDO;
            to_next     = '0;
          end
        end
        TOCANDO: begin
          if (desligar) begin
            estado_next = ARMADO;
            to_next     = '0;
          end
`ifdef SONECA_EN
          else if (adiar) begin
            estado_next = ADIADO;
            to_next     = '0;
            sn_next     = SN_W'(SONECA_MIN);
          end
`endif
          else if (carregar_alarme) begin
            estado_next = ARMADO;
            to_next     = '0;
          end else if (evento_min) begin
            if (to_reg == TO_W'(TIMEOUT_MIN - 1)) begin
              estado_next = ARMADO;
              to_next     = '0;
            end else begin
              to_next = to_reg + TO_W'(1);
            end
          end
        end
`ifdef SONECA_EN
        ADIADO: begin
          if (desligar || carregar_alarme) begin
            estado_next = ARMADO;
            sn_next     = '0;
          end else if (evento_min) begin
            if (sn_reg <= SN_W'(1)) begin
              estado_next = TOCANDO;
              sn_next     = '0;
              to_next     = '0;
            end else begin
              sn_next = sn_reg - SN_W'(1);
            end
          end
        end
`endif
        default: estado_next = INATIVO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg  <= INATIVO;
      al_hora_reg <= '0;
      al_min_reg  <= '0;
      to_reg      <= '0;
      alarme_reg  <= 1'b0;
`ifdef SONECA_EN
      sn_reg      <= '0;
`endif
    end else begin
      estado_reg  <= estado_next;
      al_hora_reg <= al_hora_next;
      al_min_reg  <= al_min_next;
      to_reg      <= to_next;
      alarme_reg  <= (estado_next == TOCANDO);
`ifdef SONECA_EN
      sn_reg      <= sn_next;
`endif
    end
  end

  assign alarme = alarme_reg;

endmodule

// File: tb/tb_despertador.sv
// Self-checking bench for despertador: directed steps plus random traffic,
// compared each cycle against a minute-of-week reference model.
module tb_despertador;

  localparam int SEG        = 2;
  localparam int TIMEOUT    = 10;
  localparam int SONECA     = 5;
  localparam int MIN_SEMANA = 7 * 24 * 60;
`ifdef SONECA_EN
  localparam bit COM_SONECA = 1'b1;
`else
  localparam bit COM_SONECA = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pulso_seg = 1'b0;
  logic       carregar_hora = 1'b0;
  logic [4:0] hora_in = '0;
  logic [5:0] min_in = '0;
  logic [2:0] dia_in = '0;
  logic       carregar_alarme = 1'b0;
  logic [4:0] alarme_hora = '0;
  logic [5:0] alarme_min = '0;
  logic       armar = 1'b0;
  logic       desligar = 1'b0;
  logic       adiar = 1'b0;
  logic       alarme;
  logic       dia_util;
  logic [4:0] hora;
  logic [5:0] minuto;
  logic [2:0] dia_semana;

  always #5 clock = ~clock;

  despertador #(
    .SEG_POR_MIN(SEG),
    .TIMEOUT_MIN(TIMEOUT),
    .SONECA_MIN (SONECA)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pulso_seg      (pulso_seg),
    .carregar_hora  (carregar_hora),
    .hora_in        (hora_in),
    .min_in         (min_in),
    .dia_in         (dia_in),
    .carregar_alarme(carregar_alarme),
    .alarme_hora    (alarme_hora),
    .alarme_min     (alarme_min),
    .armar          (armar),
    .desligar       (desligar),
    .adiar          (adiar),
    .alarme         (alarme),
    .dia_util       (dia_util),
    .hora           (hora),
    .minuto         (minuto),
    .dia_semana     (dia_semana)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: wall time as seconds + minute-of-week, alarm as flags.
  int m_seg, m_min, m_hora, m_dia, m_al_h, m_al_m, m_to, m_sn;
  bit m_pronto, m_toca, m_adiado;
  int r, alvo;

  task automatic verifica(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelo();
    bit ev;
    bit bate;
    int tm;
    ev = 1'b0;
    if (reset) begin
      m_seg = 0; m_min = 0; m_hora = 0; m_dia = 0;
      m_al_h = 0; m_al_m = 0; m_to = 0; m_sn = 0;
      m_pronto = 0; m_toca = 0; m_adiado = 0;
      return;
    end
    if (carregar_hora) begin
      m_hora = int'(hora_in); m_min = int'(min_in); m_dia = int'(dia_in); m_seg = 0;
    end else if (pulso_seg) begin
      m_seg++;
      if (m_seg == SEG) begin
        m_seg = 0;
        ev = 1'b1;
        tm = ((m_dia * 24 + m_hora) * 60 + m_min + 1) % MIN_SEMANA;
        m_dia = tm / 1440;
        m_hora = (tm / 60) % 24;
        m_min = tm % 60;
      end
    end
    bate = ev && (m_hora == m_al_h) && (m_min == m_al_m);
    if (!armar) begin
      m_pronto = 0; m_toca = 0; m_adiado = 0;
    end else if (!m_pronto) begin
      m_pronto = 1;
    end else if (m_toca) begin
      if (desligar) m_toca = 0;
      else if (COM_SONECA && adiar) begin m_toca = 0; m_adiado = 1; m_sn = SONECA; end
      else if (carregar_alarme) m_toca = 0;
      else if (ev) begin
        m_to++;
        if (m_to == TIMEOUT) m_toca = 0;
      end
    end else if (m_adiado) begin
      if (desligar || carregar_alarme) m_adiado = 0;
      else if (ev) begin
        m_sn--;
        if (m_sn == 0) begin m_adiado = 0; m_toca = 1; m_to = 0; end
      end
    end else if (bate && !carregar_alarme) begin
      m_toca = 1;
      m_to = 0;
    end
    if (carregar_alarme) begin
      m_al_h = int'(alarme_hora);
      m_al_m = int'(alarme_min);
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs checked 1 time unit later.
  task automatic ciclo();
    @(posedge clock);
    modelo();
    #1;
    verifica("alarme", 8'(alarme), 8'(m_toca));
    verifica("hora", 8'(hora), 8'(m_hora));
    verifica("minuto", 8'(minuto), 8'(m_min));
    verifica("dia_semana", 8'(dia_semana), 8'(m_dia));
    verifica("dia_util", 8'(dia_util), 8'((m_dia >= 1) && (m_dia <= 5)));
    pulso_seg = 1'b0;
    carregar_hora = 1'b0;
    carregar_alarme = 1'b0;
    desligar = 1'b0;
    adiar = 1'b0;
  endtask

  task automatic pulsos(input int n);
    repeat (n) begin
      pulso_seg = 1'b1;
      ciclo();
    end
  endtask

  task automatic carrega_hora(input int h, input int m, input int d);
    hora_in = 5'(h);
    min_in = 6'(m);
    dia_in = 3'(d);
    carregar_hora = 1'b1;
    ciclo();
  endtask

  task automatic carrega_alarme(input int h, input int m);
    alarme_hora = 5'(h);
    alarme_min = 6'(m);
    carregar_alarme = 1'b1;
    ciclo();
  endtask

  initial begin
    reset = 1'b1;
    ciclo();
    ciclo();
    verifica("reset_alarme", 8'(alarme), 8'd0);
    verifica("reset_dia_util", 8'(dia_util), 8'd0);
    $display("step reset: hora=%0d minuto=%0d dia=%0d alarme=%0d", hora, minuto, dia_semana, alarme);
    reset = 1'b0;
    armar = 1'b1;

    carrega_hora(6, 59, 1);
    carrega_alarme(7, 0);
    pulsos(2);
    verifica("t1_alarme", 8'(alarme), 8'd1);
    verifica("t1_hora", 8'(hora), 8'd7);
    verifica("t1_minuto", 8'(minuto), 8'd0);
    $display("step ring at 07:00: alarme=%0d hora=%0d minuto=%0d", alarme, hora, minuto);

    desligar = 1'b1;
    ciclo();
    verifica("desligar_alarme", 8'(alarme), 8'd0);
    pulsos(2 * 1440);
    verifica("dia_seguinte_alarme", 8'(alarme), 8'd1);
    verifica("dia_seguinte_dia", 8'(dia_semana), 8'd2);
    $display("step silence + 24h: alarme=%0d dia=%0d", alarme, dia_semana);

    pulsos(2 * (TIMEOUT - 1));
    verifica("timeout_antes", 8'(alarme), 8'd1);
    pulsos(2);
    verifica("timeout_apos", 8'(alarme), 8'd0);
    $display("step timeout: alarme=%0d minuto=%0d", alarme, minuto);

    carrega_hora(23, 59, 6);
    pulsos(2);
    verifica("wrap_semana_dia", 8'(dia_semana), 8'd0);
    verifica("wrap_semana_util", 8'(dia_util), 8'd0);
    carrega_hora(23, 59, 0);
    pulsos(2);
    verifica("wrap_dom_dia", 8'(dia_semana), 8'd1);
    verifica("wrap_dom_util", 8'(dia_util), 8'd1);
    $display("step day wrap: dia=%0d dia_util=%0d", dia_semana, dia_util);

    carrega_hora(7, 0, 3);
    ciclo();
    ciclo();
    verifica("load_igual_alarme", 8'(alarme), 8'd0);
    carrega_hora(6, 59, 3);
    pulsos(2);
    verifica("toca_de_novo", 8'(alarme), 8'd1);
    armar = 1'b0;
    ciclo();
    verifica("desarmar", 8'(alarme), 8'd0);
    armar = 1'b1;
    ciclo();
    $display("step load-equal / disarm: alarme=%0d", alarme);

    hora_in = 5'd10;
    min_in = 6'd0;
    dia_in = 3'd2;
    carregar_hora = 1'b1;
    pulso_seg = 1'b1;
    ciclo();
    pulsos(1);
    verifica("load_pulso_min", 8'(minuto), 8'd0);
    pulsos(1);
    verifica("load_pulso_min2", 8'(minuto), 8'd1);
    $display("step load+pulse: hora=%0d minuto=%0d", hora, minuto);

`ifdef SONECA_EN
    carrega_hora(6, 59, 4);
    pulsos(2);
    verifica("soneca_toca", 8'(alarme), 8'd1);
    adiar = 1'b1;
    ciclo();
    verifica("soneca_adiado", 8'(alarme), 8'd0);
    pulsos(2 * SONECA - 1);
    verifica("soneca_ainda_quieto", 8'(alarme), 8'd0);
    pulsos(1);
    verifica("soneca_volta", 8'(alarme), 8'd1);
    adiar = 1'b1;
    desligar = 1'b1;
    ciclo();
    verifica("soneca_desligar", 8'(alarme), 8'd0);
    pulsos(2 * SONECA);
    verifica("soneca_armado", 8'(alarme), 8'd0);
    $display("step snooze: alarme=%0d minuto=%0d", alarme, minuto);
`endif

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      pulso_seg = ($urandom_range(0, 1) == 1);
      if (r < 2) begin
        hora_in = 5'($urandom_range(0, 23));
        min_in = 6'($urandom_range(0, 59));
        dia_in = 3'($urandom_range(0, 6));
        carregar_hora = 1'b1;
      end else if (r < 5) begin
        alvo = (m_hora * 60 + m_min + int'($urandom_range(0, 3))) % 1440;
        alarme_hora = 5'(alvo / 60);
        alarme_min = 6'(alvo % 60);
        carregar_alarme = 1'b1;
      end else if (r == 5) begin
        armar = ~armar;
      end
      if ($urandom_range(0, 49) == 0) desligar = 1'b1;
      if ($urandom_range(0, 49) == 0) adiar = 1'b1;
      ciclo();
    end
    $display("step random: 3000 cycles, hora=%0d minuto=%0d alarme=%0d", hora, minuto, alarme);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/despertador.md
Name: despertador

Overview:
- Alarm-clock generator: the source side of the `alarme`/`dia_util`/`desligar` interface.
- Keeps time of day and day of week from a 1 Hz strobe.
- Raises `alarme` at the programmed hour:minute and holds it until the sleeper FSM answers with `desligar`, or until a timeout expires.
- `dia_util` comes from the day-of-week counter.

Parameters:
- SEG_POR_MIN, 60, seconds per minute; reduce in simulation to shorten runs.
- TIMEOUT_MIN, 10, minute events spent ringing before auto-silence.
- SONECA_MIN, 5, snooze length in minute events (used only with SONECA_EN).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pulso_seg  in  1  one-cycle strobe, one per second
- carregar_hora  in  1  load time and day from hora_in/min_in/dia_in
- hora_in  in  5  0..23
- min_in  in  6  0..59
- dia_in  in  3  0..6, 0 = domingo
- carregar_alarme  in  1  load alarm time from alarme_hora/alarme_min
- alarme_hora  in  5  0..23
- alarme_min  in  6  0..59
- armar  in  1  level; 1 = alarm enabled
- desligar  in  1  silence request from the sleeper FSM
- adiar  in  1  snooze request (ignored without SONECA_EN)
- alarme  out  1  registered alarm output
- dia_util  out  1  1 when dia_semana is 1..5
- hora  out  5  current hour
- minuto  out  6  current minute
- dia_semana  out  3  current day

Behaviour:
- Reset values: seconds=0, minuto=0, hora=0, dia_semana=0, alarm time 00:00, state INATIVO, alarme=0, dia_util=0, timeout and snooze counters=0. Reset wins over every other input.
- Time counters:
  - Seconds advance on pulso_seg and wrap SEG_POR_MIN-1 -> 0.
  - Each wrap produces one internal `evento_min` strobe in the same cycle.
  - Minute wraps 59 -> 0 and increments the hour; hour wraps 23 -> 0 and increments the day; day wraps 6 -> 0.
  - 23:59:59 on day 6 -> 00:00:00 on day 0.
- Loading time:
  - carregar_hora loads hour, minute and day, and clears seconds.
  - It has priority over a pulso_seg in the same cycle, and no evento_min is produced in that cycle.
  - Out-of-range values load unchanged; behaviour after that is undefined, and the bench must not drive them.
- Loading the alarm: carregar_alarme registers the new alarm time in 1 cycle.
- Outputs: dia_util, hora, minuto and dia_semana are registered and update in the same cycle as the counters.
- FSM states: INATIVO, ARMADO, TOCANDO (plus ADIADO under SONECA_EN).
  - Any state with armar=0 -> INATIVO next cycle; alarme=0.
  - INATIVO with armar=1 -> ARMADO.
  - ARMADO -> TOCANDO when evento_min fires and the post-increment {hora,minuto} equals the alarm time. alarme=1 from the following cycle (1-cycle latency after the pulso_seg).
  - Loading a time equal to the alarm time never triggers; only a minute advance does.
  - TOCANDO: desligar=1 -> ARMADO, alarme=0 the next cycle. The clock stays armed for the next day.
  - TOCANDO: each evento_min increments the timeout counter. At TIMEOUT_MIN -> ARMADO, alarme=0, counter cleared.
  - carregar_alarme during TOCANDO -> ARMADO (alarm silenced).
  - desligar in ARMADO or INATIVO is ignored.
- Same-cycle priority: reset > armar=0 > desligar > adiar > carregar_alarme > minute match.

Optional Feature:
SONECA_EN
- Defined:
  - In TOCANDO, adiar=1 with desligar=0 -> ADIADO; alarme=0 next cycle; snooze counter loaded with SONECA_MIN.
  - ADIADO decrements the counter on each evento_min and returns to TOCANDO at 0; the timeout counter restarts.
  - desligar in ADIADO -> ARMADO.
  - Repeated snoozes are unlimited.
- Undefined: the adiar port still exists but is ignored; there is no ADIADO state.

Decomposition:
- Package `despertador_pkg`:
  - state encoding (INATIVO, ARMADO, TOCANDO, ADIADO)
  - constants HORAS_DIA=24, MIN_HORA=60, DIAS_SEMANA=7
  - field widths (5/6/3)
- One sub-module `relogio_hms`:
  - seconds/minute/hour/day counters, load port, evento_min strobe output
  - the top level holds the FSM, alarm register and timeout/snooze counters

Test Plan:
- SEG_POR_MIN=2. Load 06:59, alarm 07:00, armar=1, pulse twice -> alarme=1 one cycle after the 2nd pulse; hora=7, minuto=0.
- While ringing, pulse desligar for 1 cycle -> alarme=0 next cycle. Advance 24 h -> alarme rises again at 07:00.
- Ring with no desligar for 10 minute events -> alarme drops on the 10th; state ARMADO.
- Load 23:59 day 6, pulse 2 s -> 00:00 day 0, dia_util=0. From 23:59 day 0 -> day 1, dia_util=1.
- Load time equal to alarm time -> alarme stays 0. armar=0 while ringing -> alarme=0 next cycle. Same cycle carregar_hora + pulso_seg -> seconds=0, no minute advance.
- SONECA_EN: adiar while ringing -> alarme=0. Rises again after exactly 5 minute events. adiar and desligar together -> ARMADO.
